// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEFAULT_MEM_LATENCY = 2;
    localparam int CNT_W               = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the memory-port arbiter.
// master: requesters plus memory model; slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ready;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ready;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic [XLEN-1:0] mem_addr;
    logic            mem_re;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    logic            busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant selection between fetch and data requesters.
// With MEM_ARB_RR_EN defined, contention alternates using last_grant;
// otherwise data always beats fetch.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_grant,
`endif
    output logic   grant_if,
    output logic   grant_d
);

    // At most one grant; a lone requester always wins.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
            grant_d  = (last_grant == OWN_IF);
            grant_if = (last_grant == OWN_D);
        end else begin
            grant_d  = d_req;
            grant_if = if_req;
        end
`else
        grant_d  = d_req;
        grant_if = if_req && !d_req;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// IDLE accepts one request, ACCESS holds a strobe for MEM_LATENCY cycles,
// DONE pulses the owner's rvalid. MEM_ARB_RR_EN selects round-robin grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
)(
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              busy_q, busy_d;
    logic              pick_if, pick_d;
    logic              if_ready, d_ready;
`ifdef MEM_ARB_RR_EN
    owner_t            last_grant_q, last_grant_d;
`endif

    mem_arb_pick u_pick (
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .grant_if   (pick_if),
        .grant_d    (pick_d)
    );

    // Next-state, latch and strobe computation for the three-state sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        cnt_d       = cnt_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        busy_d      = busy_q;
        if_ready    = 1'b0;
        d_ready     = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d || pick_if) begin
                    if_ready = pick_if;
                    d_ready  = pick_d;
                    owner_d  = pick_d ? OWN_D : OWN_IF;
                    addr_d   = pick_d ? bus.d_addr : bus.if_addr;
                    we_d     = pick_d && bus.d_we;
                    wdata_d  = pick_d ? bus.d_wdata : '0;
                    cnt_d    = CNT_W'(MEM_LATENCY - 1);
                    mem_re_d = !(pick_d && bus.d_we);
                    mem_we_d = pick_d && bus.d_we;
                    busy_d   = 1'b1;
                    state_d  = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = pick_d ? OWN_D : OWN_IF;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d  = bus.mem_rdata;
                        else                  if_rdata_d = bus.mem_rdata;
                    end
                    if_rvalid_d = (owner_q == OWN_IF);
                    d_rvalid_d  = (owner_q == OWN_D);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts an access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            cnt_q       <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            cnt_q       <= cnt_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LATENCY=2 and =1 instances).
// Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(32)) bif();
    mem_port_arbiter_if #(.XLEN(32)) bif1();

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bif.slave));
    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bif1.slave));

    int checks = 0;
    int failures = 0;

    logic [31:0] dev_mem  [logic [31:0]];
    logic [31:0] dev_mem1 [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    int          model_last;          // 0 = IF granted last, 1 = D granted last
    logic [31:0] exp_if_rdata, exp_d_rdata;
    int          gnt_cyc[$];
    int          gnt_own[$];
    int          rv_if_cyc[$];

    function automatic logic [31:0] fill(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill(a);
    endfunction

    // Memory models: writes land during strobe cycles, read data settles mid-cycle.
    always @(negedge clk) begin
        if (bif.mem_we) dev_mem[bif.mem_addr] = bif.mem_wdata;
        if (bif1.mem_we) dev_mem1[bif1.mem_addr] = bif1.mem_wdata;
        bif.mem_rdata  <= dev_mem.exists(bif.mem_addr) ? dev_mem[bif.mem_addr] : fill(bif.mem_addr);
        bif1.mem_rdata <= dev_mem1.exists(bif1.mem_addr) ? dev_mem1[bif1.mem_addr] : fill(bif1.mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.if_req = 0; bif.if_addr = 0; bif.d_req = 0; bif.d_we = 0; bif.d_addr = 0; bif.d_wdata = 0;
        bif1.if_req = 0; bif1.if_addr = 0; bif1.d_req = 0; bif1.d_we = 0; bif1.d_addr = 0; bif1.d_wdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bif.if_ready, bif.if_rvalid, bif.d_ready, bif.d_rvalid, bif.mem_re, bif.mem_we, bif.busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000", {bif.if_ready, bif.if_rvalid, bif.d_ready,
                     bif.d_rvalid, bif.mem_re, bif.mem_we, bif.busy});
        end
        checks++;
        if ({bif.if_rdata, bif.d_rdata, bif.mem_addr, bif.mem_wdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data got if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h exp=0",
                     bif.if_rdata, bif.d_rdata, bif.mem_addr, bif.mem_wdata);
        end
        checks++;
        if ({bif1.mem_re, bif1.mem_we, bif1.busy, bif1.d_rvalid, bif1.if_rvalid} !== 5'b0 || bif1.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_lat1 got=%b d_rdata=%h exp=0", {bif1.mem_re, bif1.mem_we, bif1.busy,
                     bif1.d_rvalid, bif1.if_rvalid}, bif1.d_rdata);
        end
        reset = 1'b0;
        tick();
        model_last = 0;
        exp_if_rdata = 32'h0;
        exp_d_rdata = 32'h0;
    endtask

    task automatic test_fetch();
        dev_mem[32'h100] = 32'h00500093;
        ref_mem[32'h100] = 32'h00500093;
        bif.if_req = 1; bif.if_addr = 32'h100;
        #1;
        checks++;
        if ({bif.if_ready, bif.d_ready} !== 2'b10) begin
            failures++; $display("FAIL fetch_ready got=%b exp=10", {bif.if_ready, bif.d_ready});
        end
        tick();
        bif.if_req = 0; bif.if_addr = 32'hFFFF_FFF0;
        for (int k = 1; k <= LAT; k++) begin
            checks++;
            if ({bif.mem_re, bif.mem_we, bif.busy, bif.if_rvalid} !== 4'b1010 || bif.mem_addr !== 32'h100) begin
                failures++;
                $display("FAIL fetch_strobe T+%0d got re/we/busy/rv=%b addr=%h exp=1010 addr=00000100",
                         k, {bif.mem_re, bif.mem_we, bif.busy, bif.if_rvalid}, bif.mem_addr);
            end
            tick();
        end
        checks++;
        if ({bif.if_rvalid, bif.d_rvalid, bif.mem_re, bif.busy} !== 4'b1001 || bif.if_rdata !== 32'h00500093) begin
            failures++;
            $display("FAIL fetch_rvalid got rv/drv/re/busy=%b rdata=%h exp=1001 rdata=00500093",
                     {bif.if_rvalid, bif.d_rvalid, bif.mem_re, bif.busy}, bif.if_rdata);
        end
        tick();
        checks++;
        if ({bif.if_rvalid, bif.busy} !== 2'b00 || bif.if_rdata !== 32'h00500093 || bif.d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL fetch_after got rv/busy=%b if_rdata=%h d_rdata=%h exp=00 00500093 %h",
                     {bif.if_rvalid, bif.busy}, bif.if_rdata, bif.d_rdata, exp_d_rdata);
        end
        exp_if_rdata = 32'h00500093;
        model_last = 0;
    endtask

    task automatic test_store();
        bif.d_req = 1; bif.d_we = 1; bif.d_addr = 32'h40; bif.d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bif.if_ready, bif.d_ready} !== 2'b01) begin
            failures++; $display("FAIL store_ready got=%b exp=01", {bif.if_ready, bif.d_ready});
        end
        tick();
        bif.d_req = 0; bif.d_we = 0; bif.d_wdata = 32'h0;
        for (int k = 1; k <= LAT; k++) begin
            checks++;
            if ({bif.mem_re, bif.mem_we} !== 2'b01 || bif.mem_addr !== 32'h40 || bif.mem_wdata !== 32'hDEADBEEF) begin
                failures++;
                $display("FAIL store_strobe T+%0d got re/we=%b addr=%h wdata=%h exp=01 00000040 deadbeef",
                         k, {bif.mem_re, bif.mem_we}, bif.mem_addr, bif.mem_wdata);
            end
            tick();
        end
        checks++;
        if ({bif.d_rvalid, bif.if_rvalid, bif.mem_re, bif.mem_we} !== 4'b1000 || bif.d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL store_rvalid got drv/rv/re/we=%b d_rdata=%h exp=1000 %h",
                     {bif.d_rvalid, bif.if_rvalid, bif.mem_re, bif.mem_we}, bif.d_rdata, exp_d_rdata);
        end
        tick();
        checks++;
        if (!dev_mem.exists(32'h40) || dev_mem[32'h40] !== 32'hDEADBEEF || bif.d_rvalid !== 1'b0) begin
            failures++; $display("FAIL store_mem got d_rvalid=%b mem_written=%0d exp=0 1",
                                 bif.d_rvalid, dev_mem.exists(32'h40));
        end
        ref_mem[32'h40] = 32'hDEADBEEF;
        model_last = 1;
    endtask

    // Cycle-level checker against a transaction timing model:
    // accept at a, strobes a+1..a+LAT, rvalid at a+LAT+1, next accept >= a+LAT+2.
    // mode 0 = random requesters, mode 1 = both requesting from cycle 0.
    task automatic run_cycles(input int n, input int mode);
        bit hold_if = 0, hold_d = 0, act = 0, twe = 0;
        bit free, exp_gi, exp_gd, in_win, at_rv;
        int acc = 0, own = 0;
        logic [31:0] taddr = 0, twdata = 0, trd = 0;
        gnt_cyc.delete(); gnt_own.delete(); rv_if_cyc.delete();
        for (int c = 0; c < n + LAT + 2; c++) begin
            if (c >= n) begin
                hold_if = 0; hold_d = 0;
            end else if (mode == 1) begin
                if (c == 0) begin
                    hold_if = 1; hold_d = 1;
                    bif.if_addr = 32'h300; bif.d_addr = 32'h80; bif.d_we = 0; bif.d_wdata = 32'h0;
                end
            end else begin
                if (hold_if && $urandom_range(0, 7) == 0) hold_if = 0;
                else if (!hold_if && $urandom_range(0, 2) == 0) begin
                    hold_if = 1; bif.if_addr = 32'($urandom_range(0, 31)) << 2;
                end
                if (hold_d && $urandom_range(0, 7) == 0) hold_d = 0;
                else if (!hold_d && $urandom_range(0, 2) == 0) begin
                    hold_d = 1; bif.d_addr = 32'($urandom_range(0, 31)) << 2;
                    bif.d_we = 1'($urandom_range(0, 1)); bif.d_wdata = $urandom;
                end
            end
            bif.if_req = hold_if; bif.d_req = hold_d;
            #1;
            free   = !act || (c >= acc + LAT + 2);
            exp_gd = free && hold_d && (!hold_if || !RR_MODE || model_last == 0);
            exp_gi = free && hold_if && !exp_gd;
            in_win = act && (c >= acc + 1) && (c <= acc + LAT);
            at_rv  = act && (c == acc + LAT + 1);
            if (at_rv && !twe) begin
                if (own == 1) exp_d_rdata = trd; else exp_if_rdata = trd;
            end
            checks++;
            if ({bif.if_ready, bif.d_ready} !== {exp_gi, exp_gd}) begin
                failures++; $display("FAIL arb_ready cyc=%0d got=%b exp=%b", c, {bif.if_ready, bif.d_ready}, {exp_gi, exp_gd});
            end
            checks++;
            if ({bif.mem_re, bif.mem_we} !== (in_win ? {!twe, twe} : 2'b00)) begin
                failures++; $display("FAIL arb_strobe cyc=%0d got=%b exp=%b", c, {bif.mem_re, bif.mem_we},
                                     (in_win ? {!twe, twe} : 2'b00));
            end
            if (in_win) begin
                checks++;
                if (bif.mem_addr !== taddr || (twe && bif.mem_wdata !== twdata)) begin
                    failures++; $display("FAIL arb_bus cyc=%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                                         c, bif.mem_addr, bif.mem_wdata, taddr, twdata);
                end
            end
            checks++;
            if ({bif.if_rvalid, bif.d_rvalid} !== {at_rv && own == 0, at_rv && own == 1}) begin
                failures++; $display("FAIL arb_rvalid cyc=%0d got=%b exp=%b", c, {bif.if_rvalid, bif.d_rvalid},
                                     {at_rv && own == 0, at_rv && own == 1});
            end
            checks++;
            if (bif.if_rdata !== exp_if_rdata || bif.d_rdata !== exp_d_rdata) begin
                failures++; $display("FAIL arb_rdata cyc=%0d got if=%h d=%h exp if=%h d=%h",
                                     c, bif.if_rdata, bif.d_rdata, exp_if_rdata, exp_d_rdata);
            end
            checks++;
            if (bif.busy !== (act && c >= acc + 1 && c <= acc + LAT + 1)) begin
                failures++; $display("FAIL arb_busy cyc=%0d got=%b exp=%b", c, bif.busy,
                                     (act && c >= acc + 1 && c <= acc + LAT + 1));
            end
            if (at_rv && own == 0) rv_if_cyc.push_back(c);
            if (exp_gi || exp_gd) begin
                act = 1; acc = c; own = exp_gd ? 1 : 0;
                twe    = exp_gd && bif.d_we;
                taddr  = exp_gd ? bif.d_addr : bif.if_addr;
                twdata = bif.d_wdata;
                if (twe) ref_mem[taddr] = twdata; else trd = ref_rd(taddr);
                model_last = own;
                gnt_cyc.push_back(c); gnt_own.push_back(own);
                if (mode == 0 || !RR_MODE) begin
                    if (exp_gd) hold_d = 0; else hold_if = 0;
                end
            end
            tick();
        end
        bif.if_req = 0; bif.d_req = 0; bif.d_we = 0;
    endtask

    task automatic test_contention();
        int n_exp;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        model_last = 0; exp_if_rdata = 0; exp_d_rdata = 0;
        run_cycles(16, 1);
        n_exp = RR_MODE ? 4 : 2;
        checks++;
        if (gnt_cyc.size() != n_exp) begin
            failures++; $display("FAIL contention_count got=%0d exp=%0d", gnt_cyc.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                checks++;
                if (gnt_cyc[i] != 4 * i || gnt_own[i] != ((i % 2 == 0) ? 1 : 0)) begin
                    failures++; $display("FAIL contention_grant%0d got cyc=%0d own=%0d exp cyc=%0d own=%0d",
                                         i, gnt_cyc[i], gnt_own[i], 4 * i, (i % 2 == 0) ? 1 : 0);
                end
            end
        end
        checks++;
        if (rv_if_cyc.size() == 0 || rv_if_cyc[0] != 7) begin
            failures++; $display("FAIL contention_if_rvalid got=%0d exp=7",
                                 (rv_if_cyc.size() == 0) ? -1 : rv_if_cyc[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] exp_ld;
        bif.d_req = 1; bif.d_we = 0; bif.d_addr = 32'h20;
        #1;
        checks++;
        if (bif.d_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_ready got=%b exp=1", bif.d_ready);
        end
        tick();
        bif.d_req = 0;
        checks++;
        if (bif.mem_re !== 1'b1) begin
            failures++; $display("FAIL midrst_strobe got=%b exp=1", bif.mem_re);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last = 0; exp_if_rdata = 0; exp_d_rdata = 0;
        checks++;
        if ({bif.mem_re, bif.mem_we, bif.busy} !== 3'b000 || bif.d_rdata !== 32'h0) begin
            failures++; $display("FAIL midrst_abort got re/we/busy=%b d_rdata=%h exp=000 0",
                                 {bif.mem_re, bif.mem_we, bif.busy}, bif.d_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bif.if_rvalid, bif.d_rvalid} !== 2'b00) begin
                failures++; $display("FAIL midrst_no_rvalid k=%0d got=%b exp=00", k, {bif.if_rvalid, bif.d_rvalid});
            end
            tick();
        end
        exp_ld = ref_rd(32'h24);
        bif.d_req = 1; bif.d_addr = 32'h24;
        #1;
        checks++;
        if (bif.d_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_reaccept got=%b exp=1", bif.d_ready);
        end
        tick();
        bif.d_req = 0;
        repeat (LAT) tick();
        checks++;
        if (bif.d_rvalid !== 1'b1 || bif.d_rdata !== exp_ld) begin
            failures++; $display("FAIL midrst_after got rv=%b rdata=%h exp=1 %h", bif.d_rvalid, bif.d_rdata, exp_ld);
        end
        tick();
        exp_d_rdata = exp_ld;
        model_last = 1;
    endtask

    task automatic test_latency_1();
        dev_mem1[32'h8] = 32'h12345678;
        bif1.d_req = 1; bif1.d_we = 0; bif1.d_addr = 32'h8;
        #1;
        checks++;
        if (bif1.d_ready !== 1'b1) begin
            failures++; $display("FAIL lat1_ready got=%b exp=1", bif1.d_ready);
        end
        tick();
        bif1.d_req = 0;
        checks++;
        if ({bif1.mem_re, bif1.mem_we, bif1.d_rvalid} !== 3'b100 || bif1.mem_addr !== 32'h8) begin
            failures++; $display("FAIL lat1_strobe got re/we/rv=%b addr=%h exp=100 00000008",
                                 {bif1.mem_re, bif1.mem_we, bif1.d_rvalid}, bif1.mem_addr);
        end
        tick();
        checks++;
        if ({bif1.mem_re, bif1.d_rvalid} !== 2'b01 || bif1.d_rdata !== 32'h12345678) begin
            failures++; $display("FAIL lat1_rvalid got re/rv=%b rdata=%h exp=01 12345678",
                                 {bif1.mem_re, bif1.d_rvalid}, bif1.d_rdata);
        end
        tick();
        checks++;
        if ({bif1.d_rvalid, bif1.busy} !== 2'b00 || bif1.d_rdata !== 32'h12345678) begin
            failures++; $display("FAIL lat1_after got rv/busy=%b rdata=%h exp=00 12345678",
                                 {bif1.d_rvalid, bif1.busy}, bif1.d_rdata);
        end
    endtask

    task automatic test_random();
        run_cycles(400, 0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_reset_mid_access();
        test_latency_1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified memory port between two requesters in the multi-cycle CPU: instruction fetch (IF, read-only) and data access (D, load/store).
- Sits between the multi-cycle datapath and the memory model.
- Owns the memory-side strobes and the access latency.
- Returns per-requester completion pulses; the control FSM holds its fetch and memory-access states until the pulse arrives.

Parameters:
- XLEN, 32, address/data width.
- MEM_LATENCY, 2, cycles mem_re/mem_we are held per access. Legal range is 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level. Held until if_ready.
- if_addr  in  XLEN  fetch address (PC).
- if_ready  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse when if_rdata is valid.
- if_rdata  out  XLEN  fetched instruction.
- d_req  in  1  data request, level. Held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse. Fires for both loads and stores.
- d_rdata  out  XLEN  load data.
- mem_addr  out  XLEN  memory address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, valid in the last strobe cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Three-state FSM: IDLE, ACCESS, DONE.
- Reset values: state is IDLE.
  - All outputs are 0.
  - Latched addr, we, wdata, owner, rdata and latency counter are 0.
  - last_grant is IF.
- IDLE:
  - if_ready and d_ready are combinational. At most one of them is high, and only when the matching req is high.
  - Fixed priority: D beats IF.
  - On grant, latch addr/we/wdata/owner. Load cnt = MEM_LATENCY-1. Next state is ACCESS.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_re = !we_l, mem_we = we_l. Exactly one strobe is high for MEM_LATENCY consecutive cycles.
  - cnt decrements each cycle.
  - When cnt == 0: capture mem_rdata into rdata_l (writes capture nothing). Next state is DONE.
- DONE:
  - Pulse the owner's rvalid for exactly one cycle. *_rdata = rdata_l.
  - Strobes are low. Next state is IDLE.
  - No new request is accepted in DONE.
- Timing: accept at cycle T; strobes at T+1..T+MEM_LATENCY; rvalid at T+MEM_LATENCY+1. Next accept is no earlier than T+MEM_LATENCY+2.
- *_rdata holds its value between pulses. A write does not change d_rdata.
- Requests arriving in ACCESS or DONE are ignored until IDLE; ready stays 0.
- A requester may drop req before ready with no side effects. Inputs are not sampled after acceptance.
- Simultaneous if_req and d_req in IDLE: D is granted. IF stays pending and is granted in the next IDLE if still asserted.
- Reset mid-access: the FSM returns to IDLE at the reset edge.
  - Strobes drop in the cycle after the reset edge.
  - No rvalid is issued for the aborted access.
- cnt width is 4 bits; it never wraps.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requesters are active in IDLE, the one not equal to last_grant wins.
  - last_grant updates on every grant. Its reset value is IF, so the first contention goes to D.
  - A single active requester always wins.
- Undefined: fixed D-over-IF priority. The last_grant register is not built.

Decomposition:
- Shared package holds:
  - state encoding typedef: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - owner encoding: OWN_IF=1'b0, OWN_D=1'b1.
  - the DEFAULT_MEM_LATENCY constant.
- One natural sub-module, mem_arb_pick: combinational grant selection from (if_req, d_req, last_grant).
- Counter and FSM stay in the top module.

Test Plan:
- Single fetch, MEM_LATENCY=2: if_req=1, if_addr=0x100, memory returns 0x00500093.
  - if_ready at T; mem_re high at T+1 and T+2; if_rvalid at T+3 with if_rdata=0x00500093.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF.
  - mem_we high for 2 cycles with mem_addr=0x40 and mem_wdata=0xDEADBEEF.
  - d_rvalid at T+3; mem_re is never high.
- Contention, macro undefined: if_req and d_req both high from T, held until each is accepted.
  - D accepted at T; IF accepted at T+4; if_rvalid at T+7.
- Contention, MEM_ARB_RR_EN defined: both requesters held continuously.
  - Grants alternate D, IF, D, IF at T, T+4, T+8, T+12.
- Reset mid-access: assert reset at T+1 of a load.
  - mem_re=0 and busy=0 from T+2; no d_rvalid.
  - A request after reset completes normally.
- MEM_LATENCY=1: load from 0x8 returning 0x12345678.
  - mem_re high for exactly 1 cycle; d_rvalid at T+2 with d_rdata=0x12345678.
